// File: rtl/maxnet_result_stage.sv
// Result/feedback stage of the 4-lane Maxnet process unit. It captures per-lane results,
// decides whether the run terminates, and otherwise feeds the results back as the next x.
module maxnet_result_lane #(
    parameter int VEC_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_init,
    input  logic             load_res,
    input  logic             load_x,
    input  logic [VEC_W-1:0] x_init,
    input  logic [VEC_W-1:0] pu_out,
    input  logic             pu_s,
    output logic [VEC_W-1:0] x_out,
    output logic [VEC_W-1:0] res,
    output logic             flag
);
    always_ff @(posedge clock) begin
        if (reset) begin
            x_out <= '0;
            res   <= '0;
            flag  <= 1'b0;
        end else begin
            if (load_init)
                x_out <= x_init;
            else if (load_x)
                x_out <= res;
            if (load_res) begin
                res  <= pu_out;
                flag <= pu_s;
            end
        end
    end
endmodule

module maxnet_result_stage #(
    parameter int MAX_ITER  = 16,
    parameter int ITER_W    = 5,
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 32,
    localparam int IDX_W    = $clog2(NUM_LANES)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_LANES-1:0][VEC_W-1:0] x_init,
    input  logic                            pu_valid,
    input  logic [NUM_LANES-1:0][VEC_W-1:0] pu_out,
    input  logic [NUM_LANES-1:0]            pu_s,
    output logic [NUM_LANES-1:0][VEC_W-1:0] x_out,
    output logic                            iter_req,
    output logic                            busy,
    output logic                            done,
    output logic                            winner_valid,
    output logic [IDX_W-1:0]                winner_idx,
    output logic [VEC_W-1:0]                winner_value,
    output logic                            timeout,
    output logic [ITER_W-1:0]               iter_count
);
    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, DONE} state_t;
    state_t state;

    logic [NUM_LANES-1:0][VEC_W-1:0] res;
    logic [NUM_LANES-1:0]            flags;
    logic [CNT_W-1:0]                n_alive;
    logic [IDX_W-1:0]                sole_idx;
    logic                            start_ok, capture, advance;

    // sole_idx is only meaningful when exactly one flag is set
    always_comb begin
        n_alive  = '0;
        sole_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (flags[i]) begin
                n_alive  = n_alive + CNT_W'(1);
                sole_idx = IDX_W'(i);
            end
        end
    end

    assign start_ok = start && (state == IDLE || state == DONE);
    assign capture  = (state == WAIT) && pu_valid;
    assign advance  = (state == EVAL) && (n_alive > CNT_W'(1)) && (iter_count < ITER_MAX);

    assign iter_req = (state == REQ);
    assign busy     = (state == REQ) || (state == WAIT) || (state == EVAL);
    assign done     = (state == DONE);

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            maxnet_result_lane #(.VEC_W(VEC_W)) u_lane (
                .clock     (clock),
                .reset     (reset),
                .load_init (start_ok),
                .load_res  (capture),
                .load_x    (advance),
                .x_init    (x_init[g]),
                .pu_out    (pu_out[g]),
                .pu_s      (pu_s[g]),
                .x_out     (x_out[g]),
                .res       (res[g]),
                .flag      (flags[g])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            iter_count   <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            winner_value <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        iter_count   <= '0;
                        winner_valid <= 1'b0;
                        winner_idx   <= '0;
                        winner_value <= '0;
                        timeout      <= 1'b0;
                        state        <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (pu_valid) begin
                        if (iter_count < ITER_MAX)
                            iter_count <= iter_count + ITER_W'(1);
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (n_alive == CNT_W'(1)) begin
                        winner_valid <= 1'b1;
                        winner_idx   <= sole_idx;
                        winner_value <= res[sole_idx];
                        state        <= DONE;
                    end else if (n_alive == '0) begin
                        state <= DONE;
                    end else if (iter_count >= ITER_MAX) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_result_stage.sv
// Randomized and directed bench for maxnet_result_stage with a queue-based scoreboard:
// the driver pushes expected x vectors and run outcomes, a negedge monitor pops and compares.
module tb_maxnet_result_stage;
    localparam int MI = 3;

    logic              clock = 1'b0, reset = 1'b1, start = 1'b0, pu_valid = 1'b0;
    logic [3:0][31:0]  x_init = '0, pu_out = '0;
    logic [3:0]        pu_s = '0;
    logic [3:0][31:0]  x_out;
    logic              iter_req, busy, done, winner_valid, timeout;
    logic [1:0]        winner_idx;
    logic [31:0]       winner_value;
    logic [2:0]        iter_count;

    maxnet_result_stage #(.MAX_ITER(MI), .ITER_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .x_init(x_init),
        .pu_valid(pu_valid), .pu_out(pu_out), .pu_s(pu_s), .x_out(x_out),
        .iter_req(iter_req), .busy(busy), .done(done), .winner_valid(winner_valid),
        .winner_idx(winner_idx), .winner_value(winner_value), .timeout(timeout),
        .iter_count(iter_count)
    );

    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        wv;
        logic [1:0]  idx;
        logic [31:0] val;
        logic        to;
        int          it;
    } res_t;

    res_t             rq[$];
    logic [3:0][31:0] xq[$];
    logic [3:0]       rs_q[$];
    logic [3:0][31:0] ro_q[$];
    res_t             last_res, mon_r;
    int               checks = 0, errors = 0, exp_evt = 0;
    bit               done_q = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (iter_req) begin
            if (xq.size() == 0) chk("iter_req_unexpected", 1, 0);
            else chk("x_out", x_out, xq.pop_front());
            chk("iter_req_latency", cyc, exp_evt);
            chk("req_outputs_cleared", {done, winner_valid, timeout}, 0);
        end
        if (done && !done_q) begin
            if (rq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                mon_r = rq.pop_front();
                chk("winner_valid", winner_valid, mon_r.wv);
                chk("winner_idx", winner_idx, mon_r.idx);
                chk("winner_value", winner_value, mon_r.val);
                chk("timeout", timeout, mon_r.to);
                chk("iter_count", iter_count, mon_r.it);
                chk("done_latency", cyc, exp_evt);
                chk("busy_in_done", busy, 0);
            end
        end
        done_q = done;
    end

    // Reference: walk the response list by the termination rules to get the run outcome.
    task automatic run(input logic [3:0][31:0] xi, input bit inj);
        logic [3:0][31:0] x;
        int   k, n;
        bit   ok;
        res_t r;
        x = xi; k = 0;
        r = '{wv: 1'b0, idx: 2'd0, val: 32'd0, to: 1'b0, it: 0};
        for (int i = 0; i < rs_q.size(); i++) begin
            xq.push_back(x);
            k = i + 1;
            r.it = k;
            n = $countones(rs_q[i]);
            if (n == 1) begin
                r.wv = 1'b1;
                for (int j = 0; j < 4; j++) if (rs_q[i][j]) r.idx = 2'(j);
                r.val = ro_q[i][r.idx];
                break;
            end
            if (n == 0) break;
            if (k == MI) begin r.to = 1'b1; break; end
            x = ro_q[i];
        end
        rq.push_back(r);
        last_res = r;

        @(posedge clock); #1;
        x_init = xi; start = 1'b1;
        @(posedge clock); #1;
        exp_evt = cyc; start = 1'b0;
        for (int i = 0; i < k; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok; t++) begin
                @(negedge clock);
                if (iter_req) ok = 1'b1;
            end
            chk("iter_req_wait", ok, 1);
            if (!ok) begin rs_q.delete(); ro_q.delete(); return; end
            @(posedge clock); #1;
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            pu_out = ro_q[i]; pu_s = rs_q[i]; pu_valid = 1'b1;
            if (inj) begin start = 1'b1; x_init = {$urandom, $urandom, $urandom, $urandom}; end
            @(posedge clock); #1;
            exp_evt = cyc + 1; pu_valid = 1'b0; start = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clock);
            if (done) ok = 1'b1;
        end
        chk("done_wait", ok, 1);
        rs_q.delete(); ro_q.delete();
    endtask

    task automatic add_resp(input logic [3:0] s, input logic [3:0][31:0] o);
        rs_q.push_back(s);
        ro_q.push_back(o);
    endtask

    initial begin
        logic [3:0][31:0] o, xi;
        logic [3:0]       s;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_x_out", x_out, 0);
        chk("rst_flags", {iter_req, busy, done, winner_valid, timeout}, 0);
        chk("rst_winner", {winner_idx, winner_value}, 0);
        chk("rst_iter_count", iter_count, 0);

        // pu_valid while IDLE
        @(posedge clock); #1 pu_valid = 1'b1; pu_s = 4'b0001;
        @(posedge clock); #1 pu_valid = 1'b0;
        @(negedge clock);
        chk("idle_pu_valid", {busy, done, iter_count}, 0);

        // single survivor
        o = '0; o[3] = 32'h4000_0000;
        add_resp(4'b1000, o);
        run({32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 1'b0);

        // two iterations, winner in lane 1
        o = '0; o[1] = 32'h3F80_0000; o[2] = 32'h3F00_0000;
        add_resp(4'b0110, o);
        o = '0; o[1] = 32'h3E80_0000;
        add_resp(4'b0010, o);
        run({32'h1, 32'h2, 32'h3, 32'h4}, 1'b0);

        // timeout after MI iterations
        for (int i = 0; i < MI; i++) begin
            o = '0; o[0] = 32'h3F00_0000 + 32'(i); o[1] = 32'h3E00_0000 + 32'(i);
            add_resp(4'b0011, o);
        end
        run({32'h5, 32'h6, 32'h7, 32'h8}, 1'b1);

        // no survivor
        add_resp(4'b0000, '0);
        run({32'h9, 32'hA, 32'hB, 32'hC}, 1'b0);

        // pu_valid while DONE
        @(posedge clock); #1 pu_valid = 1'b1; pu_s = 4'b0100; pu_out = {4{32'h1234_5678}};
        @(posedge clock); #1 pu_valid = 1'b0;
        @(negedge clock);
        chk("done_hold", done, 1);
        chk("done_hold_result", {winner_valid, timeout, winner_value, 29'd0, iter_count},
            {last_res.wv, last_res.to, last_res.val, 29'd0, 3'(last_res.it)});

        // reset in WAIT, then a late pu_valid
        @(posedge clock); #1;
        x_init = {32'h11, 32'h22, 32'h33, 32'h44}; start = 1'b1;
        xq.push_back(x_init);
        @(posedge clock); #1;
        exp_evt = cyc; start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; pu_valid = 1'b1; pu_s = 4'b0001; pu_out = {4{32'hFFFF}};
        @(posedge clock); #1 pu_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrun_rst_x_out", x_out, 0);
        chk("midrun_rst_flags", {iter_req, busy, done, winner_valid, timeout}, 0);
        chk("midrun_rst_winner", {winner_idx, winner_value, iter_count}, 0);

        // reset and start together
        @(posedge clock); #1 reset = 1'b1; start = 1'b1; x_init = {4{32'hABCD}};
        @(posedge clock); #1 reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_start_together", {busy, iter_req, x_out}, 0);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < MI; i++) begin
                s = 4'($urandom_range(0, 15));
                for (int j = 0; j < 4; j++)
                    o[j] = s[j] ? (($urandom & 32'h7FFF_FFFF) | 32'h1) : 32'h0;
                add_resp(s, o);
            end
            xi = {$urandom, $urandom, $urandom, $urandom};
            run(xi, $urandom_range(0, 3) == 0);
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", xq.size() + rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end
endmodule
